// File: rtl/pipe_debug_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_debug_ctrl
//  Purpose  : Debug sequencer for the 5-stage MIPS pipeline. Accepts UART
//             command bytes ('c' run, 's' single step, 'd' dump), drives the
//             global pipeline enable, and after every step/halt streams the
//             PC followed by all registers, MSB byte first, to the UART TX.
//  Ports    : clk, reset (sync, active-low)
//             i_cmd_valid/i_cmd_data/o_cmd_ready  - command byte handshake
//             i_halt_in                           - HALT reached write-back
//             i_pc_in                             - current fetch PC
//             i_reg_data_in                       - register bank port A data
//             o_dbg_sel/o_dbg_reg_addr            - port A address takeover
//             o_pipe_en                           - pipeline advance enable
//             o_tx_valid/o_tx_data/i_tx_ready     - byte stream to UART TX
//             o_halted                            - sticky HALT flag
//  Revision : 1.0  initial release
// ============================================================================
module pipe_debug_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int NUM_REGS      = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_cmd_valid,
  input  logic [7:0]               i_cmd_data,
  output logic                     o_cmd_ready,
  input  logic                     i_halt_in,
  input  logic [DATA_WIDTH-1:0]    i_pc_in,
  input  logic [DATA_WIDTH-1:0]    i_reg_data_in,
  output logic                     o_dbg_sel,
  output logic [REG_ADDR_BITS-1:0] o_dbg_reg_addr,
  output logic                     o_pipe_en,
  output logic                     o_tx_valid,
  output logic [7:0]               o_tx_data,
  input  logic                     i_tx_ready,
  output logic                     o_halted
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WI_W  = $clog2(NUM_REGS + 1);

  localparam logic [7:0]      c_CMD_RUN  = 8'h63;  // 'c'
  localparam logic [7:0]      c_CMD_STEP = 8'h73;  // 's'
  localparam logic [7:0]      c_CMD_DUMP = 8'h64;  // 'd'
  localparam logic [BI_W-1:0] c_LAST_BYTE = BI_W'(BYTES - 1);
  localparam logic [WI_W-1:0] c_LAST_WORD = WI_W'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_STEP = 3'd2,
    S_LOAD = 3'd3,
    S_SEND = 3'd4
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [WI_W-1:0]          r_word_idx, w_word_nxt;
  logic [BI_W-1:0]          r_byte_idx, w_byte_nxt;
  logic [DATA_WIDTH-1:0]    r_shift, w_shift_nxt;
  logic [DATA_WIDTH-1:0]    r_pc_lat, w_pc_lat_nxt;
  logic                     r_halted, w_halted_nxt;
  logic                     r_pipe_en, w_pipe_en_nxt;
  logic                     r_dbg_sel, w_dbg_sel_nxt;
  logic [REG_ADDR_BITS-1:0] r_dbg_reg_addr, w_addr_nxt;
  logic                     r_tx_valid, w_tx_valid_nxt;
  logic [7:0]               r_tx_data, w_tx_data_nxt;
  logic                     w_enter_load;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_word_idx     <= '0;
      r_byte_idx     <= '0;
      r_shift        <= '0;
      r_pc_lat       <= '0;
      r_halted       <= 1'b0;
      r_pipe_en      <= 1'b0;
      r_dbg_sel      <= 1'b0;
      r_dbg_reg_addr <= '0;
      r_tx_valid     <= 1'b0;
      r_tx_data      <= 8'h00;
    end else begin
      r_state        <= w_state_nxt;
      r_word_idx     <= w_word_nxt;
      r_byte_idx     <= w_byte_nxt;
      r_shift        <= w_shift_nxt;
      r_pc_lat       <= w_pc_lat_nxt;
      r_halted       <= w_halted_nxt;
      r_pipe_en      <= w_pipe_en_nxt;
      r_dbg_sel      <= w_dbg_sel_nxt;
      r_dbg_reg_addr <= w_addr_nxt;
      r_tx_valid     <= w_tx_valid_nxt;
      r_tx_data      <= w_tx_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_word_nxt   = r_word_idx;
    w_byte_nxt   = r_byte_idx;
    w_shift_nxt  = r_shift;
    w_pc_lat_nxt = r_pc_lat;
    w_halted_nxt = r_halted;
    w_enter_load = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          // Run/step are swallowed once the program has halted; dump is not.
          case (i_cmd_data)
            c_CMD_RUN:  if (!r_halted) w_state_nxt = S_RUN;
            c_CMD_STEP: if (!r_halted) w_state_nxt = S_STEP;
            c_CMD_DUMP: w_enter_load = 1'b1;
            default:    ;
          endcase
        end
      end
      S_RUN: begin
        if (i_halt_in) begin
          w_halted_nxt = 1'b1;
          w_enter_load = 1'b1;
        end
      end
      S_STEP: begin
        if (i_halt_in) w_halted_nxt = 1'b1;
        w_enter_load = 1'b1;
      end
      S_LOAD: begin
        // Word 0 is the PC snapshot; words 1..NUM_REGS come from the bank,
        // whose address was presented by the registered o_dbg_reg_addr.
        w_shift_nxt = (r_word_idx == '0) ? r_pc_lat : i_reg_data_in;
        w_byte_nxt  = '0;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (r_tx_valid && i_tx_ready) begin
          if (r_byte_idx == c_LAST_BYTE) begin
            if (r_word_idx == c_LAST_WORD) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_word_nxt  = r_word_idx + WI_W'(1);
              w_state_nxt = S_LOAD;
            end
          end else begin
            w_byte_nxt  = r_byte_idx + BI_W'(1);
            w_shift_nxt = {r_shift[DATA_WIDTH-9:0], 8'h00};
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_enter_load) begin
      w_state_nxt  = S_LOAD;
      w_word_nxt   = '0;
      w_pc_lat_nxt = i_pc_in;
    end

    // Outputs are registered from the next-state values so they line up
    // with the state they describe.
    w_pipe_en_nxt  = (w_state_nxt == S_RUN) || (w_state_nxt == S_STEP);
    w_dbg_sel_nxt  = (w_state_nxt == S_LOAD) || (w_state_nxt == S_SEND);
    w_tx_valid_nxt = (w_state_nxt == S_SEND);
    w_tx_data_nxt  = (w_state_nxt == S_SEND) ? w_shift_nxt[DATA_WIDTH-1 -: 8] : 8'h00;

    w_addr_nxt = '0;
    if (w_state_nxt == S_LOAD && w_word_nxt != '0)
      w_addr_nxt = REG_ADDR_BITS'(w_word_nxt - WI_W'(1));
    else if (w_state_nxt == S_SEND)
      w_addr_nxt = r_dbg_reg_addr;
  end

  assign o_cmd_ready    = (r_state == S_IDLE);
  assign o_dbg_sel      = r_dbg_sel;
  assign o_dbg_reg_addr = r_dbg_reg_addr;
  assign o_pipe_en      = r_pipe_en;
  assign o_tx_valid     = r_tx_valid;
  assign o_tx_data      = r_tx_data;
  assign o_halted       = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pipe_debug_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_debug_ctrl
//  Purpose  : Directed self-checking bench for pipe_debug_ctrl. Register k of
//             the modelled bank reads k*0x01010101; dumps are compared
//             byte-for-byte against values built from that rule and the PC.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_debug_ctrl;

  localparam int NB = 132;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_ready;
  logic        halt_in = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic [31:0] reg_data_in;
  logic        dbg_sel;
  logic [4:0]  dbg_reg_addr;
  logic        pipe_en;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        halted;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] dump [NB];
  int nbytes, first_tv, pe_cnt, addr_bad, stab_bad, loads;

  pipe_debug_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .i_cmd_valid    (cmd_valid),
    .i_cmd_data     (cmd_data),
    .o_cmd_ready    (cmd_ready),
    .i_halt_in      (halt_in),
    .i_pc_in        (pc_in),
    .i_reg_data_in  (reg_data_in),
    .o_dbg_sel      (dbg_sel),
    .o_dbg_reg_addr (dbg_reg_addr),
    .o_pipe_en      (pipe_en),
    .o_tx_valid     (tx_valid),
    .o_tx_data      (tx_data),
    .i_tx_ready     (tx_ready),
    .o_halted       (halted)
  );

  always #5 clk = ~clk;

  // Register bank: combinational read, reg k = k * 0x01010101.
  assign reg_data_in = {4{3'b000, dbg_reg_addr}};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [31:0] pc);
    logic [31:0] word;
    int w;
    w = i / 4;
    if (w == 0) word = pc;
    else        word = {4{8'(w - 1)}};
    return word[8*(3 - (i % 4)) +: 8];
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of T+1.
  task automatic send_cmd(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
  endtask

  // Observes the current cycle first, then advances. Holds tx_ready low for
  // 'stall' cycles per byte. Stops after 'want' transfers or a cycle budget.
  task automatic get_dump(input int stall, input int want);
    int cyc, w;
    logic [7:0] held;
    cyc = 0; w = 0; held = 8'h00;
    nbytes = 0; first_tv = -1; pe_cnt = 0; addr_bad = 0; stab_bad = 0; loads = 0;
    while (nbytes < want && cyc < 3000) begin
      if (pipe_en) pe_cnt++;
      if (dbg_sel && !tx_valid) begin
        if (dbg_reg_addr !== ((loads == 0) ? 5'd0 : 5'(loads - 1))) addr_bad++;
        loads++;
      end
      if (tx_valid) begin
        if (first_tv < 0) first_tv = cyc;
        if (w == 0) held = tx_data;
        else if (tx_data !== held) stab_bad++;
        if (w >= stall) begin
          dump[nbytes] = tx_data;
          nbytes++;
          w = 0;
          tx_ready = 1'b1;
        end else begin
          w++;
          tx_ready = 1'b0;
        end
      end else begin
        tx_ready = 1'b0;
        w = 0;
      end
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b0;
  endtask

  task automatic check_dump(input string tag, input logic [31:0] pc, input int want);
    int bad;
    bad = 0;
    for (int i = 0; i < nbytes; i++)
      if (dump[i] !== exp_byte(i, pc)) bad++;
    check({tag, " count"}, nbytes, want);
    check({tag, " bytes"}, bad, 0);
  endtask

  initial begin
    int cnt;

    // ---------------- reset values ----------------
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 8'h63;          // must not be accepted
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = 8'h00;
    check("rst cmd_ready", cmd_ready, 1);
    check("rst pipe_en", pipe_en, 0);
    check("rst tx_valid", tx_valid, 0);
    check("rst tx_data", tx_data, 0);
    check("rst dbg_sel", dbg_sel, 0);
    check("rst dbg_addr", dbg_reg_addr, 0);
    check("rst halted", halted, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post-rst pipe_en", pipe_en, 0);

    // ---------------- dump only ----------------
    pc_in = 32'h0000_0040;
    send_cmd(8'h64);
    check("d dbg_sel T+1", dbg_sel, 1);
    get_dump(0, NB);
    check_dump("d dump", 32'h0000_0040, NB);
    check("d first tx_valid", first_tv, 1);
    check("d pipe_en cycles", pe_cnt, 0);
    check("d addr sweep", addr_bad, 0);
    check("d loads", loads, 33);
    check("d end cmd_ready", cmd_ready, 1);
    check("d end dbg_sel", dbg_sel, 0);
    check("d end tx_valid", tx_valid, 0);

    // ---------------- unknown byte ----------------
    send_cmd(8'h41);
    check("0x41 cmd_ready", cmd_ready, 1);
    check("0x41 pipe_en", pipe_en, 0);
    check("0x41 dbg_sel", dbg_sel, 0);

    // ---------------- single step ----------------
    pc_in = 32'h0000_0044;
    send_cmd(8'h73);
    check("s pipe_en T+1", pipe_en, 1);
    get_dump(0, NB);
    check_dump("s dump", 32'h0000_0044, NB);
    check("s first tx_valid", first_tv, 2);
    check("s pipe_en cycles", pe_cnt, 1);
    check("s addr sweep", addr_bad, 0);
    check("s halted", halted, 0);

    // ---------------- stalled transmitter ----------------
    pc_in = 32'h1234_5678;
    send_cmd(8'h64);
    get_dump(5, NB);
    check_dump("stall dump", 32'h1234_5678, NB);
    check("stall tx stable", stab_bad, 0);
    check("stall cmd_ready", cmd_ready, 1);

    // ---------------- run until HALT ----------------
    pc_in = 32'h0000_0100;
    send_cmd(8'h63);
    cnt = 0;
    repeat (9) begin
      if (pipe_en) cnt++;
      @(negedge clk);
    end
    if (pipe_en) cnt++;
    halt_in = 1'b1;
    @(negedge clk);
    halt_in = 1'b0;
    check("c pipe_en cycles", cnt, 10);
    check("c pipe_en H+1", pipe_en, 0);
    check("c halted H+1", halted, 1);
    check("c dbg_sel H+1", dbg_sel, 1);
    check("c tx_valid H+1", tx_valid, 0);
    get_dump(0, NB);
    check_dump("c dump", 32'h0000_0100, NB);
    check("c first tx_valid", first_tv, 1);

    // 's' after halt is consumed without effect.
    send_cmd(8'h73);
    cnt = 0;
    repeat (3) begin
      if (pipe_en || dbg_sel) cnt++;
      @(negedge clk);
    end
    check("halted s activity", cnt, 0);
    check("halted s cmd_ready", cmd_ready, 1);

    // ---------------- reset mid-dump ----------------
    pc_in = 32'h0000_0200;
    send_cmd(8'h64);
    get_dump(0, 50);
    check_dump("part dump", 32'h0000_0200, 50);
    check("part tx_valid", tx_valid, 1);
    check("part byte50", tx_data, 8'h0B);
    reset = 1'b0;
    @(negedge clk);
    check("mid-rst tx_valid", tx_valid, 0);
    check("mid-rst dbg_sel", dbg_sel, 0);
    check("mid-rst tx_data", tx_data, 0);
    check("mid-rst halted", halted, 0);
    reset = 1'b1;
    @(negedge clk);
    pc_in = 32'h0000_0300;
    send_cmd(8'h64);
    get_dump(0, NB);
    check_dump("fresh dump", 32'h0000_0300, NB);
    check("fresh addr sweep", addr_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_debug_ctrl.md
# pipe_debug_ctrl

Debug sequencer for the 5-stage MIPS pipeline. It accepts single-byte commands from the UART receiver and runs the pipeline continuously or one clock at a time through a global pipeline enable. After every step or halt it takes over the register bank read port and streams the PC plus all 32 registers to the UART transmitter. It sits between the UART and the pipeline top level, beside the instruction-decode stage whose register bank it reads.

## Interface
- DATA_WIDTH, 32, register and PC word width (multiple of 8)
- REG_ADDR_BITS, 5, register bank address width
- NUM_REGS, 32, registers dumped (2^REG_ADDR_BITS)
- clk  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command byte available from UART receiver
- cmd_data  in  8  command byte
- cmd_ready  out  1  controller accepts a command this cycle
- halt_in  in  1  HALT instruction reached write-back this cycle
- pc_in  in  DATA_WIDTH  current PC from fetch stage
- reg_data_in  in  DATA_WIDTH  register bank port A read data (combinational read)
- dbg_sel  out  1  debug owns register bank port A address
- dbg_reg_addr  out  REG_ADDR_BITS  register bank address while dbg_sel=1
- pipe_en  out  1  pipeline advance enable (all stage registers and PC)
- tx_valid  out  1  byte offered to UART transmitter
- tx_data  out  8  byte offered
- tx_ready  in  1  transmitter accepts byte
- halted  out  1  sticky: program reached HALT

## Operation
- States: IDLE, RUN, STEP, LOAD, SEND.
- cmd_ready = (state==IDLE). A command is accepted on a rising edge with cmd_valid & cmd_ready & reset=1.
- IDLE: 0x63 'c' -> RUN. 0x73 's' -> STEP. 0x64 'd' -> LOAD (dump only). Any other byte is consumed and ignored. When halted=1, 'c' and 's' are consumed and ignored. 'd' is still honoured.
- RUN: pipe_en=1. If halt_in=1 on an edge, set halted, pipe_en=0 from the next cycle, go to LOAD.
- STEP: pipe_en=1 for exactly one cycle, then go to LOAD. If halt_in=1 in that cycle, set halted.
- On entry to LOAD from any state: word_idx=0 and pc_in is latched.
- LOAD: dbg_sel=1, pipe_en=0.
  - word_idx 0 loads the latched PC into the shift register.
  - word_idx k in 1..NUM_REGS drives dbg_reg_addr=k-1 and captures reg_data_in.
  - Then go to SEND with byte_idx=0.
- SEND: tx_valid=1, tx_data = word byte byte_idx, MSB byte first.
  - On tx_valid & tx_ready, byte_idx increments.
  - After the last byte of a word, word_idx increments and the state goes to LOAD.
  - After the last byte of word NUM_REGS, the state goes to IDLE.
- A full dump is (NUM_REGS+1)*DATA_WIDTH/8 bytes (132 at defaults).
- dbg_sel stays 1 in LOAD and SEND and is 0 otherwise. dbg_reg_addr=0 when dbg_sel=0.
- halt_in is ignored outside RUN and STEP.
- Counters: word_idx is 6 bits and byte_idx is 2 bits. Neither wraps, because the terminal checks fire first.

## Timing
- Reset values (all outputs registered except cmd_ready):
  - state=IDLE; pipe_en=0, tx_valid=0, tx_data=0, dbg_sel=0, dbg_reg_addr=0, halted=0.
  - cmd_ready reads 1 during reset, but nothing is accepted.
- Command accepted at edge T: new state and pipe_en are visible from cycle T+1.
- STEP: pipe_en high in cycle T+1 only. LOAD is in T+2. First tx_valid is in T+3.
- RUN with halt_in sampled at edge H: pipe_en=0 and halted=1 from H+1. LOAD is in H+1. tx_valid is in H+2.
- tx_valid, once raised, stays high with stable tx_data until tx_ready is seen. The next byte appears in the cycle after the transfer. There is one tx_valid=0 LOAD cycle between words.
- Back-to-back commands: the earliest next acceptance is the cycle after the final byte transfer.
- Reset low mid-operation, sampled at an edge: all outputs take reset values from the next cycle. The partial dump is abandoned, with no completion of the current byte, and halted clears.

## Test plan
- Reset, then 'd' with PC=0x00000040 and reg k=k*0x01010101 -> 132 bytes: 00 00 00 40, 00 00 00 00, 01 01 01 01, …, 1F 1F 1F 1F.
- 's' with tx_ready tied 1 -> pipe_en high exactly one cycle (T+1), first tx_valid at T+3, and dbg_reg_addr sweeps 0..31.
- 'c', halt_in pulsed 10 cycles later -> pipe_en high 10 cycles then 0, halted=1, dump follows. A later 's' is consumed and pipe_en stays 0.
- tx_ready held low 5 cycles per byte -> tx_data stable while stalled and no byte skipped or duplicated (132 transfers).
- Byte 0x41 in IDLE -> cmd_ready stays 1, no state change, pipe_en stays 0.
- Reset low at byte 50 of a dump -> tx_valid=0 and dbg_sel=0 next cycle, then a 'd' produces a full fresh 132-byte dump.
